mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width and width of each of hi and lo; legal range 8..64.
REQ-002 Port Clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port reset, input, 1: synchronous, active-high reset.
REQ-004 Port start, input, 1: request to begin an operation.
REQ-005 Port op, input, 2: operation select; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port rs_val, input, WIDTH: multiplicand or dividend.
REQ-007 Port rt_val, input, WIDTH: multiplier or divisor.
REQ-008 Port hi_we / lo_we, input, 1 each: direct write of hi / lo (MTHI / MTLO).
REQ-009 Port wdata, input, WIDTH: data for hi_we / lo_we.
REQ-010 Port busy, output, 1: operation in progress.
REQ-011 Port done, output, 1: one-cycle completion pulse.
REQ-012 Port div_by_zero, output, 1: one-cycle pulse, coincident with done.
REQ-013 Port hi / lo, output, WIDTH each: result registers, read by MFHI / MFLO.

Function
REQ-014 States: IDLE, CALC, FIX, DONE; the state register drives busy = (CALC or FIX) and done = DONE.
REQ-015 start is accepted only in IDLE or DONE and is ignored in CALC and FIX.
REQ-016 On accept, op is latched, operand magnitudes are latched (two's-complement absolute value for MULT/DIV, raw value for MULTU/DIVU), result signs are recorded, the iteration counter is cleared, and the FSM enters CALC.
REQ-017 Divide by zero (op DIV or DIVU, rt_val == 0) at accept: next state is DONE with div_by_zero = 1; hi and lo are unchanged.
REQ-018 CALC performs exactly WIDTH iterations, one per cycle: radix-2 shift-add for multiply, restoring shift-subtract for divide, on a 2*WIDTH-bit internal accumulator.
REQ-019 After the last iteration, CALC moves to FIX.
REQ-020 In FIX, hi and lo are written in a single edge, then the FSM moves to DONE.
REQ-021 Multiply result: hi:lo = full 2*WIDTH-bit product, negated when exactly one signed operand was negative.
REQ-022 Divide result: lo = quotient, truncated toward zero; hi = remainder, carrying the sign of the dividend.
REQ-023 Signed overflow case MIN / -1: lo = MIN and hi = 0, with no trap.
REQ-024 Latency: when start is accepted in cycle 0, done = 1 in cycle WIDTH+2, and hi/lo hold the new values in that cycle. Divide by zero: done in cycle 1.
REQ-025 DONE lasts one cycle and returns to IDLE unless start is accepted in that cycle (back-to-back operation).
REQ-026 hi_we / lo_we write wdata in the next edge only when busy = 0; they are ignored while busy = 1.
REQ-027 If hi_we and an accepted start occur in the same cycle, both take effect. The operation result later overwrites hi.

Reset
REQ-028 While reset is high at an edge: state = IDLE, counter = 0, hi = 0, lo = 0, accumulator = 0; busy, done and div_by_zero = 0.
REQ-029 Reset asserted mid-operation aborts the operation; no done pulse is produced; start in the reset cycle is ignored.

Structure
REQ-030 Shared package mdu_pkg SHALL hold the op encoding enum (mdu_op_t) and the FSM state enum (mdu_state_t).
REQ-031 Counter width SHALL be $clog2(WIDTH+1).
REQ-032 One combinational sub-module, mdu_step, SHALL compute a single multiply/divide iteration. No other sub-modules.

Verification
REQ-033 MULT rs=-3, rt=7 (WIDTH=32) -> done in cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-034 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-035 DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-036 DIVU 100 / 0 after hi=0x11, lo=0x22 -> done and div_by_zero high in cycle 1; hi and lo unchanged.
REQ-037 MULT started, start and hi_we pulsed in cycle 5, reset asserted in cycle 10 -> hi and lo unaffected by cycle 5 inputs; after reset, hi=lo=0, busy=0, and no done pulse.
REQ-038 Back-to-back: start held high through DONE -> second result's done arrives exactly WIDTH+2 cycles after the first done.

Source files
------------

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op and state encodings for the multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input mdu_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one radix-2 iteration: shift-add multiply or restoring divide
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] sub_diff;
  logic             fits;

  always_comb begin
    // Multiply: upper half accumulates, lower half shifts out the multiplier bits.
    addend  = acc[0] ? operand : '0;
    add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};

    // Divide: partial remainder takes the next dividend bit; quotient bits shift in at the bottom.
    rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    fits      = (rem_shift >= {1'b0, operand});
    sub_diff  = rem_shift[WIDTH-1:0] - operand;

    if (is_div) begin
      if (fits) acc_next = {sub_diff, acc[WIDTH-2:0], 1'b1};
      else      acc_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {add_sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with hi/lo result registers
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mdu_state_t         state, next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_next;
  logic [WIDTH-1:0]   operand_q;
  logic               div_q, neg_lo_q, neg_hi_q, dbz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  mdu_op_t            op_in;
  logic               accept, div_zero, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   res_hi, res_lo;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (div_q),
    .acc      (acc),
    .operand  (operand_q),
    .acc_next (acc_next)
  );

  always_comb begin
    op_in    = mdu_op_t'(op);
    div_zero = op_is_div(op_in) && (rt_val == '0);
    a_neg    = op_is_signed(op_in) && rs_val[WIDTH-1];
    b_neg    = op_is_signed(op_in) && rt_val[WIDTH-1];
    a_mag    = a_neg ? -rs_val : rs_val;
    b_mag    = b_neg ? -rt_val : rt_val;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        next_state = ST_IDLE;
        if (start) begin
          accept     = 1'b1;
          next_state = div_zero ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: if (cnt == LAST_CNT) next_state = ST_FIX;
      ST_FIX:  next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
    busy        = (state == ST_CALC) || (state == ST_FIX);
    done        = (state == ST_DONE);
    div_by_zero = done && dbz_q;
  end

  always_ff @(posedge Clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Magnitudes were iterated; restore signs when committing to hi/lo.
  always_comb begin
    prod = neg_lo_q ? -acc : acc;
    if (div_q) begin
      res_lo = neg_lo_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      res_hi = neg_hi_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end else begin
      res_lo = prod[WIDTH-1:0];
      res_hi = prod[2*WIDTH-1:WIDTH];
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      cnt       <= '0;
      acc       <= '0;
      operand_q <= '0;
      div_q     <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (accept) begin
        cnt       <= '0;
        acc       <= {{WIDTH{1'b0}}, a_mag};
        operand_q <= b_mag;
        div_q     <= op_is_div(op_in);
        neg_lo_q  <= a_neg ^ b_neg;
        neg_hi_q  <= op_is_div(op_in) ? a_neg : (a_neg ^ b_neg);
        dbz_q     <= div_zero;
      end else if (state == ST_CALC) begin
        acc <= acc_next;
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_FIX) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end else if (!busy) begin
        if (hi_we) hi_q <= wdata;
        if (lo_we) lo_q <= wdata;
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
